// File: rtl/iob_pcie_rx_engine_pkg.sv
// Shared definitions for the RIFFA RX receive engine: FSM state encodings and default widths.
package iob_pcie_rx_engine_pkg;

    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned FIFO_ADDR_W_DEF = 4;
    localparam int unsigned LEN_W_DEF       = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRecv = 2'd1,
        StDone = 2'd2
    } rx_state_e;

endpackage

// File: rtl/iob_pcie_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is presented combinationally on pop_data.
module iob_pcie_rx_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(1 << ADDR_W);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   level_q;
    logic              do_push;
    logic              do_pop;

    assign full     = (level_q == FULL_LEVEL);
    assign empty    = (level_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Drive zero when empty so the head port is clean after reset or a flush.
    assign pop_data = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/iob_pcie_rx_engine.sv
// RIFFA RX channel engine: accepts one host->FPGA transaction, buffers its words in a FIFO and
// streams them out with valid/ready, reporting done/abort and the latched transaction fields.
module iob_pcie_rx_engine
    import iob_pcie_rx_engine_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned FIFO_ADDR_W = FIFO_ADDR_W_DEF,
    parameter int unsigned LEN_W       = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              chnl_rx,
    output logic              chnl_rx_ack,
    input  logic              chnl_rx_last,
    input  logic [LEN_W-1:0]  chnl_rx_len,
    input  logic [30:0]       chnl_rx_off,
    input  logic [DATA_W-1:0] chnl_rx_data,
    input  logic              chnl_rx_data_valid,
    output logic              chnl_rx_data_ren,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic [LEN_W-1:0]  rx_len,
    output logic [30:0]       rx_off,
    output logic              rx_last,
    output logic [LEN_W-1:0]  rx_count
);

    rx_state_e        state_q;
    logic             ack_q;
    logic             done_q;
    logic             abort_q;
    logic [LEN_W-1:0] len_q;
    logic [30:0]      off_q;
    logic             last_q;
    logic [LEN_W-1:0] count_q;

    logic fifo_full;
    logic fifo_empty;
    logic beat;
    logic last_beat;

    // Request a word only while there is room and the transaction still owes words.
    assign chnl_rx_data_ren = (state_q == StRecv) && !fifo_full && (count_q < len_q);
    assign beat             = chnl_rx_data_valid && chnl_rx_data_ren;
    assign last_beat        = beat && (count_q == len_q - 1'b1);

    assign chnl_rx_ack = ack_q;
    assign done        = done_q;
    assign abort       = abort_q;
    assign busy        = (state_q != StIdle);
    assign rx_len      = len_q;
    assign rx_off      = off_q;
    assign rx_last     = last_q;
    assign rx_count    = count_q;
    assign out_valid   = !fifo_empty;

    iob_pcie_rx_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (beat),
        .push_data (chnl_rx_data),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            len_q   <= '0;
            off_q   <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (chnl_rx) begin
                        len_q   <= chnl_rx_len;
                        off_q   <= chnl_rx_off;
                        last_q  <= chnl_rx_last;
                        count_q <= '0;
                        ack_q   <= 1'b1;
                        if (chnl_rx_len == '0) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            state_q <= StRecv;
                        end
                    end
                end
                StRecv: begin
                    if (beat) begin
                        count_q <= count_q + 1'b1;
                    end
                    // A completing beat wins over a simultaneous drop of chnl_rx.
                    if (last_beat) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (!chnl_rx) begin
                        abort_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StDone: begin
                    if (!chnl_rx) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_pcie_rx_engine.sv
// Directed bench for iob_pcie_rx_engine: drives RIFFA RX transactions and checks stream and status.
module tb_iob_pcie_rx_engine;

    logic        clk;
    logic        rst_n;
    logic        chnl_rx;
    logic        chnl_rx_ack;
    logic        chnl_rx_last;
    logic [31:0] chnl_rx_len;
    logic [30:0] chnl_rx_off;
    logic [31:0] chnl_rx_data;
    logic        chnl_rx_data_valid;
    logic        chnl_rx_data_ren;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        abort;
    logic [31:0] rx_len;
    logic [30:0] rx_off;
    logic        rx_last;
    logic [31:0] rx_count;

    int n_checks = 0;
    int n_errs   = 0;

    logic [31:0] got[$];
    int done_cnt  = 0;
    int abort_cnt = 0;
    int ack_cnt   = 0;
    int ren_cnt   = 0;
    int beat_cnt  = 0;
    bit rand_ready = 1'b0;

    iob_pcie_rx_engine dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .chnl_rx            (chnl_rx),
        .chnl_rx_ack        (chnl_rx_ack),
        .chnl_rx_last       (chnl_rx_last),
        .chnl_rx_len        (chnl_rx_len),
        .chnl_rx_off        (chnl_rx_off),
        .chnl_rx_data       (chnl_rx_data),
        .chnl_rx_data_valid (chnl_rx_data_valid),
        .chnl_rx_data_ren   (chnl_rx_data_ren),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .busy               (busy),
        .done               (done),
        .abort              (abort),
        .rx_len             (rx_len),
        .rx_off             (rx_off),
        .rx_last            (rx_last),
        .rx_count           (rx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor: sees pre-edge values, so each one-cycle pulse is counted once.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) got.push_back(out_data);
        if (done) done_cnt++;
        if (abort) abort_cnt++;
        if (chnl_rx_ack) ack_cnt++;
        if (chnl_rx_data_ren) ren_cnt++;
        if (chnl_rx_data_valid && chnl_rx_data_ren) beat_cnt++;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom % 2) == 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".ack"}, 32'(chnl_rx_ack), 32'd0);
        check_eq({tag, ".ren"}, 32'(chnl_rx_data_ren), 32'd0);
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".out_data"}, out_data, 32'd0);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".done"}, 32'(done), 32'd0);
        check_eq({tag, ".abort"}, 32'(abort), 32'd0);
        check_eq({tag, ".rx_len"}, rx_len, 32'd0);
        check_eq({tag, ".rx_off"}, 32'(rx_off), 32'd0);
        check_eq({tag, ".rx_last"}, 32'(rx_last), 32'd0);
        check_eq({tag, ".rx_count"}, rx_count, 32'd0);
    endtask

    // Raise chnl_rx and check the ack arrives exactly one cycle later.
    task automatic start_txn(input string tag, input logic [31:0] len, input logic [30:0] off,
                             input logic last);
        @(negedge clk);
        chnl_rx      = 1'b1;
        chnl_rx_len  = len;
        chnl_rx_off  = off;
        chnl_rx_last = last;
        #1;
        check_eq({tag, ".ack_early"}, 32'(chnl_rx_ack), 32'd0);
        @(negedge clk);
        check_eq({tag, ".ack"}, 32'(chnl_rx_ack), 32'd1);
        check_eq({tag, ".busy"}, 32'(busy), 32'd1);
        check_eq({tag, ".done_at_ack"}, 32'(done), (len == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic end_txn(input string tag);
        @(negedge clk);
        chnl_rx = 1'b0;
        @(negedge clk);
        check_eq({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    // Offer words base, base+1, ... until n are taken or the cycle budget runs out.
    task automatic drive_words(input int n, input logic [31:0] base, input bit rand_valid,
                               input int max_cycles, output int taken);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < max_cycles) begin
            @(negedge clk);
            chnl_rx_data_valid = rand_valid ? (($urandom % 2) == 1) : 1'b1;
            chnl_rx_data       = base + 32'(idx);
            #1;
            if (chnl_rx_data_valid && chnl_rx_data_ren) idx++;
            cyc++;
        end
        @(negedge clk);
        chnl_rx_data_valid = 1'b0;
        taken = idx;
    endtask

    task automatic check_stream(input string tag, input int base, input int n,
                                input logic [31:0] first);
        check_eq({tag, ".count"}, 32'(got.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < got.size()) check_eq({tag, ".word"}, got[base+i], first + 32'(i));
        end
    endtask

    initial begin
        int taken;
        int gb;
        int d0;
        int a0;
        int k0;
        int r0;
        int b0;

        rst_n              = 1'b0;
        chnl_rx            = 1'b0;
        chnl_rx_last       = 1'b0;
        chnl_rx_len        = '0;
        chnl_rx_off        = '0;
        chnl_rx_data       = '0;
        chnl_rx_data_valid = 1'b0;
        out_ready          = 1'b0;
        wait_cycles(3);
        check_reset_state("reset");
        rst_n = 1'b1;
        wait_cycles(2);

        // 1: four back-to-back words, consumer always ready.
        gb = got.size(); d0 = done_cnt; k0 = ack_cnt;
        out_ready = 1'b1;
        start_txn("t1", 32'd4, 31'd0, 1'b1);
        drive_words(4, 32'hA0, 1'b0, 20, taken);
        wait_cycles(4);
        check_eq("t1.done_once", 32'(done_cnt - d0), 32'd1);
        check_eq("t1.ack_once", 32'(ack_cnt - k0), 32'd1);
        check_eq("t1.rx_count", rx_count, 32'd4);
        check_eq("t1.rx_len", rx_len, 32'd4);
        check_eq("t1.rx_last", 32'(rx_last), 32'd1);
        check_eq("t1.busy_in_done", 32'(busy), 32'd1);
        check_eq("t1.ren_in_done", 32'(chnl_rx_data_ren), 32'd0);
        check_stream("t1", gb, 4, 32'hA0);
        end_txn("t1");

        // 2: 20 words with the consumer stalled; FIFO fills at 16.
        gb = got.size(); d0 = done_cnt;
        out_ready = 1'b0;
        start_txn("t2", 32'd20, 31'd5, 1'b0);
        drive_words(20, 32'h100, 1'b0, 30, taken);
        check_eq("t2.stall_taken", 32'(taken), 32'd16);
        check_eq("t2.stall_count", rx_count, 32'd16);
        check_eq("t2.ren_full", 32'(chnl_rx_data_ren), 32'd0);
        check_eq("t2.head_valid", 32'(out_valid), 32'd1);
        check_eq("t2.head_data", out_data, 32'h100);
        check_eq("t2.no_early_done", 32'(done_cnt - d0), 32'd0);
        out_ready = 1'b1;
        drive_words(4, 32'h110, 1'b0, 30, taken);
        wait_cycles(25);
        check_eq("t2.done_once", 32'(done_cnt - d0), 32'd1);
        check_eq("t2.rx_count", rx_count, 32'd20);
        check_eq("t2.rx_off", 32'(rx_off), 32'd5);
        check_stream("t2", gb, 20, 32'h100);
        end_txn("t2");

        // 3: zero-length transaction.
        d0 = done_cnt; r0 = ren_cnt; k0 = ack_cnt;
        start_txn("t3", 32'd0, 31'd7, 1'b1);
        wait_cycles(4);
        check_eq("t3.ren_never", 32'(ren_cnt - r0), 32'd0);
        check_eq("t3.done_once", 32'(done_cnt - d0), 32'd1);
        check_eq("t3.no_reack", 32'(ack_cnt - k0), 32'd1);
        check_eq("t3.fifo_empty", 32'(out_valid), 32'd0);
        check_eq("t3.rx_count", rx_count, 32'd0);
        check_eq("t3.rx_off", 32'(rx_off), 32'd7);
        end_txn("t3");

        // 4: host drops chnl_rx after three of eight words.
        gb = got.size(); d0 = done_cnt; a0 = abort_cnt;
        start_txn("t4", 32'd8, 31'd0, 1'b0);
        drive_words(3, 32'h200, 1'b0, 20, taken);
        chnl_rx = 1'b0;
        @(negedge clk);
        check_eq("t4.abort", 32'(abort), 32'd1);
        check_eq("t4.idle", 32'(busy), 32'd0);
        wait_cycles(4);
        check_eq("t4.abort_once", 32'(abort_cnt - a0), 32'd1);
        check_eq("t4.no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("t4.rx_count", rx_count, 32'd3);
        check_stream("t4", gb, 3, 32'h200);

        // 5: random valid and ready; excess words must never be requested.
        gb = got.size(); d0 = done_cnt; b0 = beat_cnt;
        rand_ready = 1'b1;
        start_txn("t5", 32'd6, 31'd1, 1'b0);
        drive_words(6, 32'h300, 1'b1, 200, taken);
        @(negedge clk);
        chnl_rx_data_valid = 1'b1;
        wait_cycles(4);
        chnl_rx_data_valid = 1'b0;
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        wait_cycles(10);
        check_eq("t5.beats", 32'(beat_cnt - b0), 32'd6);
        check_eq("t5.done_once", 32'(done_cnt - d0), 32'd1);
        check_eq("t5.rx_count", rx_count, 32'd6);
        check_stream("t5", gb, 6, 32'h300);
        end_txn("t5");

        // 6: reset mid-transfer, then a fresh two-word transaction.
        d0 = done_cnt; a0 = abort_cnt;
        out_ready = 1'b0;
        start_txn("t6", 32'd8, 31'd3, 1'b1);
        drive_words(2, 32'h400, 1'b0, 20, taken);
        rst_n   = 1'b0;
        chnl_rx = 1'b0;
        #1;
        check_reset_state("t6.midreset");
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
        check_eq("t6.no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("t6.no_abort", 32'(abort_cnt - a0), 32'd0);
        gb = got.size(); d0 = done_cnt;
        out_ready = 1'b1;
        start_txn("t6b", 32'd2, 31'd0, 1'b0);
        drive_words(2, 32'h500, 1'b0, 20, taken);
        wait_cycles(4);
        check_eq("t6b.done_once", 32'(done_cnt - d0), 32'd1);
        check_eq("t6b.rx_count", rx_count, 32'd2);
        check_stream("t6b", gb, 2, 32'h500);
        end_txn("t6b");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
